// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU/extender codes,
// FSM state codes and instruction-class one-hot indices.
package mips_mc_ctrl_pkg;

    // Opcode / funct fields
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // ALUCtrl one-hot codes
    localparam logic [7:0] ALU_NONE  = 8'h00;
    localparam logic [7:0] ALU_ADD   = 8'h01;
    localparam logic [7:0] ALU_SUB   = 8'h02;
    localparam logic [7:0] ALU_OR    = 8'h04;
    localparam logic [7:0] ALU_PASSB = 8'h08;

    // ExtCtrl codes
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // FSM state codes
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    // Instruction-class one-hot bit positions
    localparam int unsigned C_ADDU = 0;
    localparam int unsigned C_SUBU = 1;
    localparam int unsigned C_ORI  = 2;
    localparam int unsigned C_LUI  = 3;
    localparam int unsigned C_LW   = 4;
    localparam int unsigned C_SW   = 5;
    localparam int unsigned C_BEQ  = 6;
    localparam int unsigned C_J    = 7;
    localparam int unsigned C_NOP  = 8;
    localparam int unsigned C_ILL  = 9;
    localparam int unsigned CLS_W  = 10;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decoder: latched opcode/funct -> instruction class one-hot and the
// decode-level datapath selects that stay constant for the whole instruction.
module mips_ctrl_decode
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0]       op,
    input  logic [5:0]       fn,
    input  logic             is_nop,
    output logic [CLS_W-1:0] cls,
    output logic             reg3src,
    output logic             alusrc,
    output logic [1:0]       extctrl,
    output logic [7:0]       aluctrl,
    output logic             datatoreg,
    output logic             pcimm
);

    // Classify the instruction; anything unrecognised lands in C_ILL
    always_comb begin
        cls = '0;
        unique case (op)
            OP_R: begin
                if (is_nop)              cls[C_NOP]  = 1'b1;
                else if (fn == FN_ADDU)  cls[C_ADDU] = 1'b1;
                else if (fn == FN_SUBU)  cls[C_SUBU] = 1'b1;
                else                     cls[C_ILL]  = 1'b1;
            end
            OP_ORI:  cls[C_ORI] = 1'b1;
            OP_LUI:  cls[C_LUI] = 1'b1;
            OP_LW:   cls[C_LW]  = 1'b1;
            OP_SW:   cls[C_SW]  = 1'b1;
            OP_BEQ:  cls[C_BEQ] = 1'b1;
            OP_J:    cls[C_J]   = 1'b1;
            default: cls[C_ILL] = 1'b1;
        endcase
    end

    // Derive the per-class datapath selects
    always_comb begin
        reg3src   = cls[C_ADDU] | cls[C_SUBU];
        alusrc    = cls[C_ORI] | cls[C_LUI] | cls[C_LW] | cls[C_SW];
        datatoreg = cls[C_LW];
        pcimm     = cls[C_BEQ];

        if (cls[C_LUI])                          extctrl = EXT_LUI;
        else if (cls[C_LW] | cls[C_SW] | cls[C_BEQ]) extctrl = EXT_SIGN;
        else                                     extctrl = EXT_ZERO;

        if (cls[C_ADDU] | cls[C_LW] | cls[C_SW])  aluctrl = ALU_ADD;
        else if (cls[C_SUBU] | cls[C_BEQ])        aluctrl = ALU_SUB;
        else if (cls[C_ORI])                      aluctrl = ALU_OR;
        else if (cls[C_LUI])                      aluctrl = ALU_PASSB;
        else                                      aluctrl = ALU_NONE;
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: latches the fetched instruction and sequences
// FETCH/DECODE/EXEC/MEM/WB, producing datapath controls plus PC/IR write strobes.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        IRWE,
    output logic        PCWE,
    output logic        Br,
    output logic        Jump,
    output logic        PCIMM,
    output logic        Reg3Src,
    output logic        DatatoReg,
    output logic        RegWE,
    output logic        ALUSrc,
    output logic [7:0]  ALUCtrl,
    output logic        DMWE,
    output logic [1:0]  ExtCtrl,
    output logic        retire,
    output logic        halted
);

    logic [2:0]       state_q, state_d;
    logic [5:0]       op_q, fn_q;
    logic             nop_q;
    logic [CLS_W-1:0] cls;
    logic             dec_reg3src, dec_alusrc, dec_datatoreg, dec_pcimm;
    logic [1:0]       dec_extctrl;
    logic [7:0]       dec_aluctrl;
    logic             sel_on, last;

    mips_ctrl_decode u_decode (
        .op        (op_q),
        .fn        (fn_q),
        .is_nop    (nop_q),
        .cls       (cls),
        .reg3src   (dec_reg3src),
        .alusrc    (dec_alusrc),
        .extctrl   (dec_extctrl),
        .aluctrl   (dec_aluctrl),
        .datatoreg (dec_datatoreg),
        .pcimm     (dec_pcimm)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Instruction register, loaded only in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= OP_R;
            fn_q  <= 6'h00;
            nop_q <= 1'b1;
        end else if (state_q == FETCH) begin
            op_q  <= instr[31:26];
            fn_q  <= instr[5:0];
            nop_q <= (instr == 32'h0);
        end
    end

    // Next state and all outputs; everything is forced low while reset is high
    always_comb begin
        state_d   = state_q;
        sel_on    = 1'b0;
        last      = 1'b0;
        IRWE      = 1'b0;
        Br        = 1'b0;
        Jump      = 1'b0;
        RegWE     = 1'b0;
        DMWE      = 1'b0;
        halted    = 1'b0;

        case (state_q)
            FETCH: begin
                IRWE    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                sel_on = 1'b1;
                if (cls[C_ILL] && HALT_ON_ILLEGAL) begin
                    sel_on  = 1'b0;
                    state_d = HALT;
                end else if (cls[C_J] | cls[C_NOP] | cls[C_ILL]) begin
                    Jump    = cls[C_J];
                    last    = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sel_on = 1'b1;
                if (cls[C_BEQ]) begin
                    Br      = zero;
                    last    = 1'b1;
                    state_d = FETCH;
                end else if (cls[C_LW] | cls[C_SW]) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                sel_on = 1'b1;
                if (cls[C_SW]) begin
                    DMWE    = 1'b1;
                    last    = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                sel_on  = 1'b1;
                RegWE   = 1'b1;
                last    = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        PCWE      = last;
        retire    = last;
        Reg3Src   = sel_on & dec_reg3src;
        ALUSrc    = sel_on & dec_alusrc;
        DatatoReg = sel_on & dec_datatoreg;
        PCIMM     = sel_on & dec_pcimm;
        ExtCtrl   = sel_on ? dec_extctrl : EXT_ZERO;
        ALUCtrl   = sel_on ? dec_aluctrl : ALU_NONE;

        // Reset asynchronously kills any in-flight strobe, including FETCH's IRWE
        if (reset) begin
            IRWE = 1'b0; PCWE = 1'b0; Br = 1'b0; Jump = 1'b0; PCIMM = 1'b0;
            Reg3Src = 1'b0; DatatoReg = 1'b0; RegWE = 1'b0; ALUSrc = 1'b0;
            ALUCtrl = ALU_NONE; DMWE = 1'b0; ExtCtrl = EXT_ZERO;
            retire = 1'b0; halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: one instance per HALT_ON_ILLEGAL setting, driven
// in lockstep; per-cycle output vectors are compared against hand-built expectations.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;

    logic       irwe0, pcwe0, br0, jump0, pcimm0, r3_0, d2r0, rwe0, asrc0, dmwe0, ret0, halt0;
    logic [7:0] alu0;
    logic [1:0] ext0;
    logic       irwe1, pcwe1, br1, jump1, pcimm1, r3_1, d2r1, rwe1, asrc1, dmwe1, ret1, halt1;
    logic [7:0] alu1;
    logic [1:0] ext1;
    logic [21:0] obs0, obs1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .IRWE(irwe0), .PCWE(pcwe0), .Br(br0), .Jump(jump0), .PCIMM(pcimm0),
        .Reg3Src(r3_0), .DatatoReg(d2r0), .RegWE(rwe0), .ALUSrc(asrc0),
        .ALUCtrl(alu0), .DMWE(dmwe0), .ExtCtrl(ext0), .retire(ret0), .halted(halt0)
    );

    mips_mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .IRWE(irwe1), .PCWE(pcwe1), .Br(br1), .Jump(jump1), .PCIMM(pcimm1),
        .Reg3Src(r3_1), .DatatoReg(d2r1), .RegWE(rwe1), .ALUSrc(asrc1),
        .ALUCtrl(alu1), .DMWE(dmwe1), .ExtCtrl(ext1), .retire(ret1), .halted(halt1)
    );

    assign obs0 = {irwe0, pcwe0, br0, jump0, pcimm0, r3_0, d2r0, rwe0, asrc0,
                   alu0, dmwe0, ext0, ret0, halt0};
    assign obs1 = {irwe1, pcwe1, br1, jump1, pcimm1, r3_1, d2r1, rwe1, asrc1,
                   alu1, dmwe1, ext1, ret1, halt1};

    // Packs one expected output vector in the same order as obs0/obs1
    function automatic logic [21:0] ev(input logic irwe, pcwe, br, jump, pcimm, r3, d2r,
                                       rwe, asrc, input logic [7:0] alu, input logic dmwe,
                                       input logic [1:0] ext, input logic ret, hlt);
        return {irwe, pcwe, br, jump, pcimm, r3, d2r, rwe, asrc, alu, dmwe, ext, ret, hlt};
    endfunction

    logic [21:0] F, N, Z, H;
    initial begin
        F = ev(1,0,0,0,0,0,0,0,0,8'h00,0,2'b00,0,0);   // FETCH
        N = ev(0,1,0,0,0,0,0,0,0,8'h00,0,2'b00,1,0);   // nop retire in DECODE
        Z = 22'h0;
        H = ev(0,0,0,0,0,0,0,0,0,8'h00,0,2'b00,0,1);   // HALT
    end

    task automatic test_reset();
        logic [21:0] ex [0:1];
        #3;
        n_cmp++; if (obs0 !== Z) begin n_bad++; $display("FAIL reset_hold dut0: got %h want %h", obs0, Z); end
        n_cmp++; if (obs1 !== Z) begin n_bad++; $display("FAIL reset_hold dut1: got %h want %h", obs1, Z); end
        @(posedge clk); #1;
        reset = 1'b0;
        instr = 32'h0;
        ex = '{F, N};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL reset_release cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL reset_release cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addu();
        logic [21:0] ex [0:3];
        logic [21:0] s, w;
        s = ev(0,0,0,0,0,1,0,0,0,8'h01,0,2'b00,0,0);
        w = ev(0,1,0,0,0,1,0,1,0,8'h01,0,2'b00,1,0);
        ex = '{F, s, s, w};
        for (int c = 0; c < 4; c++) begin
            instr = (c == 0) ? 32'h00221821 : 32'hFFFFFFFF;
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL addu cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL addu cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_sw();
        logic [21:0] ex [0:8];
        logic [31:0] iv [0:8];
        logic [21:0] l, lw, s, sm;
        int rets;
        l  = ev(0,0,0,0,0,0,1,0,1,8'h01,0,2'b01,0,0);
        lw = ev(0,1,0,0,0,0,1,1,1,8'h01,0,2'b01,1,0);
        s  = ev(0,0,0,0,0,0,0,0,1,8'h01,0,2'b01,0,0);
        sm = ev(0,1,0,0,0,0,0,0,1,8'h01,1,2'b01,1,0);
        ex = '{F, l, l, l, lw, F, s, s, sm};
        iv = '{32'h8C020004, 0, 0, 0, 0, 32'hAC020008, 0, 0, 0};
        rets = 0;
        for (int c = 0; c < 9; c++) begin
            instr = iv[c];
            @(negedge clk);
            rets += int'(ret0);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL lw_sw cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL lw_sw cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
        n_cmp++; if (rets !== 2) begin n_bad++; $display("FAIL lw_sw_retires: got %0d want 2", rets); end
    endtask

    task automatic test_beq();
        logic [21:0] ex [0:5];
        logic        zv [0:5];
        logic [21:0] bs, bt, bn;
        bs = ev(0,0,0,0,1,0,0,0,0,8'h02,0,2'b01,0,0);
        bt = ev(0,1,1,0,1,0,0,0,0,8'h02,0,2'b01,1,0);
        bn = ev(0,1,0,0,1,0,0,0,0,8'h02,0,2'b01,1,0);
        ex = '{F, bs, bt, F, bs, bn};
        // zero high in the second beq's DECODE must not produce Br
        zv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            instr = 32'h10220002;
            zero  = zv[c];
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL beq cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL beq cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_j_lui_nop();
        logic [21:0] ex [0:7];
        logic [31:0] iv [0:7];
        logic [21:0] j, u, uw;
        j  = ev(0,1,0,1,0,0,0,0,0,8'h00,0,2'b00,1,0);
        u  = ev(0,0,0,0,0,0,0,0,1,8'h08,0,2'b10,0,0);
        uw = ev(0,1,0,0,0,0,0,1,1,8'h08,0,2'b10,1,0);
        ex = '{F, j, F, u, u, uw, F, N};
        iv = '{32'h08000010, 32'hFFFFFFFF, 32'h3C01FFFF, 32'hFFFFFFFF,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        for (int c = 0; c < 8; c++) begin
            instr = iv[c];
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL j_lui_nop cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL j_lui_nop cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] ex [0:3];
        logic [21:0] s, w;
        s = ev(0,0,0,0,0,1,0,0,0,8'h01,0,2'b00,0,0);
        w = ev(0,1,0,0,0,1,0,1,0,8'h01,0,2'b00,1,0);
        ex = '{F, s, s, w};
        for (int c = 0; c < 4; c++) begin
            instr = (c == 0) ? 32'h00221821 : 32'h0;
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL reset_mid_pre cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        // Still in WB with RegWE high; reset must drop everything without a clock edge
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (obs0 !== Z) begin n_bad++; $display("FAIL reset_mid_async dut0: got %h want %h", obs0, Z); end
        n_cmp++; if (obs1 !== Z) begin n_bad++; $display("FAIL reset_mid_async dut1: got %h want %h", obs1, Z); end
        @(posedge clk); #1;
        reset = 1'b0;
        ex[0] = F;
        ex[1] = N;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (obs0 !== ex[c]) begin n_bad++; $display("FAIL reset_mid_post cyc %0d dut0: got %h want %h", c, obs0, ex[c]); end
            n_cmp++; if (obs1 !== ex[c]) begin n_bad++; $display("FAIL reset_mid_post cyc %0d dut1: got %h want %h", c, obs1, ex[c]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [21:0] e0 [0:5];
        logic [21:0] e1 [0:5];
        e0 = '{F, N, F, N, F, N};
        e1 = '{F, Z, H, H, H, H};
        for (int c = 0; c < 6; c++) begin
            instr = 32'hFC000000;
            @(negedge clk);
            n_cmp++; if (obs0 !== e0[c]) begin n_bad++; $display("FAIL illegal_nop cyc %0d dut0: got %h want %h", c, obs0, e0[c]); end
            n_cmp++; if (obs1 !== e1[c]) begin n_bad++; $display("FAIL illegal_halt cyc %0d dut1: got %h want %h", c, obs1, e1[c]); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #2;
        n_cmp++; if (obs1 !== Z) begin n_bad++; $display("FAIL halt_reset dut1: got %h want %h", obs1, Z); end
        @(posedge clk); #1;
        reset = 1'b0;
        instr = 32'h0;
        e0[0] = F;
        e0[1] = N;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (obs0 !== e0[c]) begin n_bad++; $display("FAIL halt_recover cyc %0d dut0: got %h want %h", c, obs0, e0[c]); end
            n_cmp++; if (obs1 !== e0[c]) begin n_bad++; $display("FAIL halt_recover cyc %0d dut1: got %h want %h", c, obs1, e0[c]); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_sw();
        test_beq();
        test_j_lui_nop();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
